// File: rtl/imm_field_encoder_pkg.sv
// Shared types and constants for the immediate-field encoder.
package imm_field_encoder_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } encState_t;

    // Field-width select as carried on in_sel24
    typedef enum logic {
        SEL14 = 1'b0,
        SEL24 = 1'b1
    } fieldSel_t;

    localparam int IMM14_W = 14;
    localparam int IMM24_W = 24;

    // Saturation limits, already laid out as they appear in the 24-bit output field
    localparam logic [23:0] IMM14_MAX = 24'h001FFF;
    localparam logic [23:0] IMM14_MIN = 24'h002000;
    localparam logic [23:0] IMM24_MAX = 24'h7FFFFF;
    localparam logic [23:0] IMM24_MIN = 24'h800000;

endpackage

// File: rtl/imm_field_encoder_if.sv
// Request/result handshake bundle for the immediate-field encoder.
interface imm_field_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_target;
    logic [31:0] in_base;
    logic        in_sel24;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_field;
    logic        out_ovf;
    logic        out_misalign;

    modport master (
        output in_valid, in_target, in_base, in_sel24, out_ready,
        input  in_ready, out_valid, out_field, out_ovf, out_misalign
    );

    modport slave (
        input  in_valid, in_target, in_base, in_sel24, out_ready,
        output in_ready, out_valid, out_field, out_ovf, out_misalign
    );
endinterface

// File: rtl/imm_range_check.sv
// Range check of a shifted offset against the selected field width, producing
// the final field contents (truncated, or clamped when SATURATE is set).
module imm_range_check
    import imm_field_encoder_pkg::*;
#(
    parameter int SATURATE = 0
) (
    input  logic [31:0] val,
    input  logic        sel24,
    output logic        fits,
    output logic [23:0] sat_field
);

    logic fits14;
    logic fits24;

    // A value fits when every bit from the field's sign bit upward agrees.
    always_comb begin
        fits14 = (&val[31:IMM14_W-1]) | ~(|val[31:IMM14_W-1]);
        fits24 = (&val[31:IMM24_W-1]) | ~(|val[31:IMM24_W-1]);
        fits   = sel24 ? fits24 : fits14;

        if (sel24) begin
            sat_field = val[IMM24_W-1:0];
        end else begin
            sat_field = {{(IMM24_W-IMM14_W){1'b0}}, val[IMM14_W-1:0]};
        end

        if (!fits && (SATURATE != 0)) begin
            if (sel24) begin
                sat_field = val[31] ? IMM24_MIN : IMM24_MAX;
            end else begin
                sat_field = val[31] ? IMM14_MIN : IMM14_MAX;
            end
        end
    end

endmodule

// File: rtl/imm_field_encoder.sv
// Narrows (target - base) >>> SHIFT into a 14- or 24-bit immediate field,
// flagging overflow and misalignment, and counts overflowed results.
//
//  state | meaning
//  ------+---------------------------------------------------------
//  IDLE  | in_ready=1, waiting for a request
//  CALC  | difference, arithmetic shift and misalignment computed
//  CHECK | range check, field formed, outputs registered
//  DONE  | out_valid=1, outputs held until out_ready
module imm_field_encoder
    import imm_field_encoder_pkg::*;
#(
    parameter int SHIFT    = 2,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    imm_field_encoder_if.slave bus,
    output logic [CNT_W-1:0]  ovf_count
);

    encState_t   state;
    logic [31:0] targetReg;
    logic [31:0] baseReg;
    fieldSel_t   selReg;
    logic [31:0] valReg;
    logic        misReg;

    logic        inReady;
    logic        outValid;
    logic [23:0] outField;
    logic        outOvf;
    logic        outMis;
    logic [CNT_W-1:0] ovfCnt;

    logic [31:0] diff;
    logic [31:0] diffShifted;
    logic [31:0] lowMask;
    logic        diffMis;
    logic        fits;
    logic [23:0] fieldNext;

    // Offset arithmetic; the mask form keeps SHIFT=0 legal (misalign is then 0).
    always_comb begin
        diff        = targetReg - baseReg;
        diffShifted = $signed(diff) >>> SHIFT;
        lowMask     = (32'd1 << SHIFT) - 32'd1;
        diffMis     = |(diff & lowMask);
    end

    imm_range_check #(.SATURATE(SATURATE)) rangeCheck (
        .val       (valReg),
        .sel24     (selReg == SEL24),
        .fits      (fits),
        .sat_field (fieldNext)
    );

    // Sequencer, datapath registers, registered outputs and overflow counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            targetReg <= '0;
            baseReg   <= '0;
            selReg    <= SEL14;
            valReg    <= '0;
            misReg    <= 1'b0;
            inReady   <= 1'b1;
            outValid  <= 1'b0;
            outField  <= '0;
            outOvf    <= 1'b0;
            outMis    <= 1'b0;
            ovfCnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && inReady) begin
                        targetReg <= bus.in_target;
                        baseReg   <= bus.in_base;
                        selReg    <= fieldSel_t'(bus.in_sel24);
                        inReady   <= 1'b0;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    valReg <= diffShifted;
                    misReg <= diffMis;
                    state  <= CHECK;
                end
                CHECK: begin
                    outField <= fieldNext;
                    outOvf   <= ~fits;
                    outMis   <= misReg;
                    outValid <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        if (outOvf && !(&ovfCnt)) begin
                            ovfCnt <= ovfCnt + CNT_W'(1);
                        end
                        outValid <= 1'b0;
                        inReady  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    inReady  <= 1'b1;
                    outValid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready     = inReady;
    assign bus.out_valid    = outValid;
    assign bus.out_field    = outField;
    assign bus.out_ovf      = outOvf;
    assign bus.out_misalign = outMis;
    assign ovf_count        = ovfCnt;

endmodule

// File: tb/tb_imm_field_encoder.sv
// Bench for imm_field_encoder: two instances (wrap and saturate) share one
// stimulus stream and are checked every cycle against a transaction-level model.
module tb_imm_field_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inValid = 1'b0;
    logic [31:0] inTarget = '0;
    logic [31:0] inBase = '0;
    logic        inSel24 = 1'b0;
    logic        outReady = 1'b0;
    logic [7:0]  count0;
    logic [7:0]  count1;

    int total = 0;
    int bad = 0;

    imm_field_encoder_if ifc0 ();
    imm_field_encoder_if ifc1 ();

    assign ifc0.in_valid  = inValid;
    assign ifc0.in_target = inTarget;
    assign ifc0.in_base   = inBase;
    assign ifc0.in_sel24  = inSel24;
    assign ifc0.out_ready = outReady;
    assign ifc1.in_valid  = inValid;
    assign ifc1.in_target = inTarget;
    assign ifc1.in_base   = inBase;
    assign ifc1.in_sel24  = inSel24;
    assign ifc1.out_ready = outReady;

    imm_field_encoder #(.SHIFT(2), .SATURATE(0), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .bus(ifc0), .ovf_count(count0)
    );
    imm_field_encoder #(.SHIFT(2), .SATURATE(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .bus(ifc1), .ovf_count(count1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] f0;   // wrapping field
        logic [23:0] f1;   // saturating field
        logic        ovf;
        logic        mis;
    } exp_t;

    // Reference: signed offset arithmetic on wide integers.
    function automatic exp_t model(input logic [31:0] t, input logic [31:0] b, input logic sel);
        exp_t        e;
        logic [31:0] diff;
        longint      d, v, hi, lo, m, w;
        diff = t - b;
        d    = longint'($signed(diff));
        v    = d >>> 2;
        hi   = sel ? 64'sd8388607 : 64'sd8191;
        lo   = -hi - 1;
        m    = sel ? 64'sd16777216 : 64'sd16384;
        w    = ((v % m) + m) % m;
        e.mis = (diff % 4) != 0;
        e.ovf = (v > hi) || (v < lo);
        e.f0  = 24'(w);
        if (e.ovf) e.f1 = (v < 0) ? 24'(((lo % m) + m) % m) : 24'(hi);
        else       e.f1 = 24'(w);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: whether a transaction is in flight and edges since its accept.
    bit   started = 0;
    bit   busy = 0;
    bit   afterReset = 0;
    int   age = 0;
    int   mdlCnt = 0;
    exp_t pend;

    // Per-cycle compare, then advance the model with the inputs the next edge samples.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready0", ifc0.in_ready, !busy);
            chk("in_ready1", ifc1.in_ready, !busy);
            chk("out_valid0", ifc0.out_valid, busy && age >= 2);
            chk("out_valid1", ifc1.out_valid, busy && age >= 2);
            if (busy && age >= 2) begin
                chk("field0", ifc0.out_field, pend.f0);
                chk("field1", ifc1.out_field, pend.f1);
                chk("ovf0", ifc0.out_ovf, pend.ovf);
                chk("ovf1", ifc1.out_ovf, pend.ovf);
                chk("mis0", ifc0.out_misalign, pend.mis);
                chk("mis1", ifc1.out_misalign, pend.mis);
            end
            if (afterReset) begin
                chk("rst_field0", ifc0.out_field, 0);
                chk("rst_field1", ifc1.out_field, 0);
                chk("rst_ovf", ifc0.out_ovf, 0);
                chk("rst_mis", ifc0.out_misalign, 0);
            end
            chk("ovf_count0", count0, mdlCnt);
            chk("ovf_count1", count1, mdlCnt);
        end
        if (reset) begin
            started    = 1;
            busy       = 0;
            age        = 0;
            mdlCnt     = 0;
            afterReset = 1;
        end else if (started) begin
            afterReset = 0;
            if (!busy) begin
                if (inValid) begin
                    busy = 1;
                    age  = 0;
                    pend = model(inTarget, inBase, inSel24);
                end
            end else if (age >= 2 && outReady) begin
                busy = 0;
                if (pend.ovf && mdlCnt != 255) mdlCnt++;
            end else begin
                age++;
            end
        end
    end

    // One directed transaction; caller is positioned just after a rising edge.
    task automatic runTxn(input logic [31:0] t, input logic [31:0] b, input logic sel,
                          input int hold, input logic [23:0] e0, input logic [23:0] e1,
                          input logic eOvf, input logic eMis);
        int n;
        n = 0;
        while (!ifc0.in_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("accept_wait", ifc0.in_ready, 1);
        inTarget = t; inBase = b; inSel24 = sel; inValid = 1'b1; outReady = 1'b0;
        @(posedge clk); #1;
        inValid = 1'b0;
        n = 0;
        while (!ifc0.out_valid && n < 10) begin @(posedge clk); #1; n++; end
        // accept edge, then CHECK edge, then DONE edge
        chk("latency", n, 2);
        chk("lit_field0", ifc0.out_field, e0);
        chk("lit_field1", ifc1.out_field, e1);
        chk("lit_ovf", ifc0.out_ovf, eOvf);
        chk("lit_mis", ifc0.out_misalign, eMis);
        repeat (hold) begin @(posedge clk); #1; end
        if (hold > 0) begin
            chk("stall_field0", ifc0.out_field, e0);
            chk("stall_in_ready", ifc0.in_ready, 0);
        end
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
    endtask

    exp_t pin;

    initial begin
        // pin the model against hand-computed values
        pin = model(32'h1000, 32'h0, 1'b0);
        chk("pin1", {pin.f0, pin.ovf, pin.mis}, {24'h000400, 1'b0, 1'b0});
        pin = model(32'h0F0, 32'h100, 1'b0);
        chk("pin2", {pin.f0, pin.ovf}, {24'h003FFC, 1'b0});
        pin = model(32'h8000, 32'h0, 1'b0);
        chk("pin3", {pin.f0, pin.f1, pin.ovf}, {24'h002000, 24'h001FFF, 1'b1});
        pin = model(32'h0200_0000, 32'h0, 1'b1);
        chk("pin4", {pin.f0, pin.f1, pin.ovf}, {24'h800000, 24'h7FFFFF, 1'b1});
        pin = model(32'h0, 32'h8004, 1'b0);
        chk("pin5", {pin.f0, pin.f1, pin.ovf}, {24'h001FFF, 24'h002000, 1'b1});

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        runTxn(32'h1000, 32'h0, 1'b0, 0, 24'h000400, 24'h000400, 1'b0, 1'b0);
        runTxn(32'h0F0, 32'h100, 1'b0, 0, 24'h003FFC, 24'h003FFC, 1'b0, 1'b0);
        runTxn(32'h8000, 32'h0, 1'b0, 0, 24'h002000, 24'h001FFF, 1'b1, 1'b0);
        chk("cnt_after_ovf", count0, 1);
        runTxn(32'h7FFC, 32'h0, 1'b0, 0, 24'h001FFF, 24'h001FFF, 1'b0, 1'b0);
        runTxn(32'h0, 32'h8000, 1'b0, 0, 24'h002000, 24'h002000, 1'b0, 1'b0);
        runTxn(32'h0, 32'h8004, 1'b0, 0, 24'h001FFF, 24'h002000, 1'b1, 1'b0);
        runTxn(32'h01FF_FFFC, 32'h0, 1'b1, 0, 24'h7FFFFF, 24'h7FFFFF, 1'b0, 1'b0);
        runTxn(32'h0200_0000, 32'h0, 1'b1, 0, 24'h800000, 24'h7FFFFF, 1'b1, 1'b0);
        runTxn(32'h0, 32'h0200_0000, 1'b1, 0, 24'h800000, 24'h800000, 1'b0, 1'b0);
        runTxn(32'h6, 32'h0, 1'b0, 5, 24'h000001, 24'h000001, 1'b0, 1'b1);
        chk("cnt_directed", count1, 3);

        // reset while in CHECK discards the transaction
        inTarget = 32'h8000; inBase = 32'h0; inSel24 = 1'b0; inValid = 1'b1; outReady = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_in_ready", ifc0.in_ready, 1);
        chk("rst_out_valid", ifc0.out_valid, 0);
        chk("rst_count", count0, 0);
        repeat (4) begin @(posedge clk); #1; end
        chk("rst_no_result", count1, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int mode;
            int off;
            mode     = $urandom_range(0, 3);
            inBase   = $urandom;
            off      = (mode == 0) ? $urandom_range(0, 65536) - 32768 :
                       (mode == 1) ? $urandom_range(0, 67108864) - 33554432 :
                       (mode == 2) ? $urandom_range(0, 64) - 32 : int'($urandom);
            inTarget = inBase + 32'(off);
            inSel24  = 1'($urandom_range(0, 1));
            inValid  = 1'($urandom_range(0, 1));
            outReady = ($urandom_range(0, 3) != 0);
            reset    = ($urandom_range(0, 149) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0; inValid = 1'b0; outReady = 1'b1;
        repeat (8) begin @(posedge clk); #1; end

        // 300 overflowing results: counter must stick at all-ones
        inTarget = 32'h8000; inBase = 32'h0; inSel24 = 1'b0; inValid = 1'b1; outReady = 1'b1;
        repeat (1215) begin @(posedge clk); #1; end
        inValid = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        chk("cnt_sat0", count0, 8'hFF);
        chk("cnt_sat1", count1, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
